mix_column_sched: RTL and testbench



---
 rtl/mix_column_sched.sv | 179 +++++++++++++++++
 tb/tb_mix_column_sched.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_column_sched.sv
// mix_column_sched: time-shares a column-wide AES MixColumns datapath across
// the four columns of a 128-bit state, COLS_PER_CYC columns per clock, behind
// valid/ready handshakes on both sides.
// Optional feature macro: MIXCOL_INV_EN adds the inv port and InvMixColumns.
module mix_column_sched #(
  parameter int COLS_PER_CYC = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
`ifdef MIXCOL_INV_EN
  input  logic         inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (COLS_PER_CYC != 1 && COLS_PER_CYC != 2 && COLS_PER_CYC != 4) begin : g_bad_cols
    $error("mix_column_sched: COLS_PER_CYC must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Column group width, held in 3 bits so col_cnt + STEP never overflows.
  localparam logic [2:0] STEP = 3'(COLS_PER_CYC);

  state_t       state_q, state_d;
  logic [1:0]   col_cnt_q, col_cnt_d;
  logic [127:0] work_q, work_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;
  logic [127:0] mixed;
`ifdef MIXCOL_INV_EN
  logic         inv_q, inv_d;
`endif

  // GF(2^8) multiply by 2 with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // Forward MixColumns on one column; col[31:24] is row 0.
  function automatic logic [31:0] mix_fwd(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] t0, t1, t2, t3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    t0 = xtime(a0);
    t1 = xtime(a1);
    t2 = xtime(a2);
    t3 = xtime(a3);
    return {t0 ^ (t1 ^ a1) ^ a2 ^ a3,
            a0 ^ t1 ^ (t2 ^ a2) ^ a3,
            a0 ^ a1 ^ t2 ^ (t3 ^ a3),
            (t0 ^ a0) ^ a1 ^ a2 ^ t3};
  endfunction

`ifdef MIXCOL_INV_EN
  // Inverse MixColumns on one column; 9x/Bx/Dx/Ex come from 2x, 4x and 8x.
  function automatic logic [31:0] mix_inv(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = xtime(a[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction
`endif

  // Mix the active column group of the work register in place; other columns pass through.
  always_comb begin
    mixed = work_q;
    for (int c = 0; c < 4; c++) begin
      if ((3'(c) >= {1'b0, col_cnt_q}) && (3'(c) < ({1'b0, col_cnt_q} + STEP))) begin
`ifdef MIXCOL_INV_EN
        mixed[127-32*c -: 32] = inv_q ? mix_inv(work_q[127-32*c -: 32])
                                      : mix_fwd(work_q[127-32*c -: 32]);
`else
        mixed[127-32*c -: 32] = mix_fwd(work_q[127-32*c -: 32]);
`endif
      end
    end
  end

  // Sequencer next state plus the registered handshake outputs derived from it.
  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    work_d    = work_q;
`ifdef MIXCOL_INV_EN
    inv_d     = inv_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          work_d    = in_data;
          col_cnt_d = 2'd0;
          state_d   = BUSY;
`ifdef MIXCOL_INV_EN
          inv_d     = inv;
`endif
        end
      end
      BUSY: begin
        work_d    = mixed;
        col_cnt_d = col_cnt_q + 2'(COLS_PER_CYC);
        if (({1'b0, col_cnt_q} + STEP) == 3'd4) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State, work register and output flags; reset also discards any partial state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_cnt_q   <= 2'd0;
      work_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MIXCOL_INV_EN
      inv_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      work_q      <= work_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef MIXCOL_INV_EN
      inv_q       <= inv_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  // The work register is only exposed while the result is being offered.
  assign out_data  = out_valid_q ? work_q : '0;

endmodule

// File: tb/tb_mix_column_sched.sv
// Bench for mix_column_sched: three instances (1, 2 and 4 columns per cycle)
// each checked every cycle against a transaction-level model that computes the
// expected state with a generic GF(2^8) matrix product.
module tb_mix_column_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

`ifdef MIXCOL_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] C6_IN    = 128'hc6c6c6c6_d4d4d4d5_c6c6c6c6_d4d4d4d5;
  localparam logic [127:0] C6_OUT   = 128'hc6c6c6c6_d5d5d7d6_c6c6c6c6_d5d5d7d6;

  // Shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ ({8{x[7]}} & 8'h1B);
    end
    return p;
  endfunction

  // Whole-state (Inv)MixColumns as a circulant matrix product per column.
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic iv);
    logic [7:0] row [4];
    logic [7:0] a [4];
    logic [7:0] acc;
    logic [127:0] r;
    if (iv) begin
      row[0] = 8'h0e; row[1] = 8'h0b; row[2] = 8'h0d; row[3] = 8'h09;
    end else begin
      row[0] = 8'h02; row[1] = 8'h03; row[2] = 8'h01; row[3] = 8'h01;
    end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) a[k] = s[127-8*(4*c+k) -: 8];
      for (int rr = 0; rr < 4; rr++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc = acc ^ gmul(row[(k - rr + 4) % 4], a[k]);
        r[127-8*(4*c+rr) -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic check(input string nm, input int c, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cols=%0d): got %h want %h", nm, c, act, exp);
    end
  endtask

  for (genvar k = 0; k < 3; k++) begin : g_inst
    localparam int C   = 1 << k;
    localparam int LAT = 4 / C;

    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    mix_column_sched #(.COLS_PER_CYC(C)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
`ifdef MIXCOL_INV_EN
      .inv       (inv),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
    );

    // Model: 0 = idle, 1 = working (m_left cycles to go), 2 = result offered.
    int           m_phase = 0;
    int           m_left  = 0;
    logic [127:0] m_exp   = '0;

    always @(posedge clk) begin
      if (!rst_n) begin
        m_phase <= 0;
        m_left  <= 0;
        m_exp   <= '0;
      end else begin
        case (m_phase)
          0: if (in_valid) begin
               m_phase <= 1;
               m_left  <= LAT;
               m_exp   <= ref_mix(in_data, inv & INV_EN);
             end
          1: begin
               if (m_left == 1) m_phase <= 2;
               m_left <= m_left - 1;
             end
          default: if (out_ready) m_phase <= 0;
        endcase
      end
    end

    always @(negedge clk) begin
      check("in_ready",  C, 128'(in_ready),  128'(m_phase == 0));
      check("out_valid", C, 128'(out_valid), 128'(m_phase == 2));
      check("busy",      C, 128'(busy),      128'(m_phase != 0));
      check("out_data",  C, out_data,        (m_phase == 2) ? m_exp : 128'h0);
    end

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    // Send one state from IDLE with out_ready high; check result and latency.
    task automatic run_one(input logic [127:0] d, input logic iv, input logic [127:0] want, input string nm);
      int n;
      bit got;
      logic [127:0] od;
      in_data = d; inv = iv; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      inv      = ~iv;
      n = 0; got = 1'b0; od = '0;
      while (n < 20 && !got) begin
        @(posedge clk);
        n++;
        @(negedge clk);
        if (out_valid) begin
          got = 1'b1;
          od  = out_data;
        end
      end
      check({nm, "_data"}, C, od, want);
      check({nm, "_latency"}, C, 128'(n), 128'(LAT));
      tick();
    endtask

    initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; inv = 1'b0; out_ready = 1'b0;
      tick(); tick();
      rst_n = 1'b1;

      run_one(FIPS_IN, 1'b0, FIPS_OUT, "fips");
      run_one(C6_IN, 1'b0, C6_OUT, "c6");

      // Backpressure: hold the result for 5 cycles while a second state waits.
      in_data = FIPS_IN; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      repeat (LAT) tick();
      for (int i = 0; i < 5; i++) begin
        if (i == 1) begin
          in_valid = 1'b1;
          in_data  = C6_IN;
        end
        @(negedge clk);
        check("bp_hold_data", C, out_data, FIPS_OUT);
        check("bp_hold_in_ready", C, 128'(in_ready), 128'(0));
        tick();
      end
      out_ready = 1'b1;
      tick();
      @(negedge clk);
      check("bp_release_in_ready", C, 128'(in_ready), 128'(1));
      tick();
      in_valid = 1'b0;
      repeat (LAT) tick();
      @(negedge clk);
      check("bp_second_valid", C, 128'(out_valid), 128'(1));
      check("bp_second_data", C, out_data, C6_OUT);
      tick();

      // Reset in the middle of the column sweep.
      in_data = FIPS_IN; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (2 / C) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_out_valid", C, 128'(out_valid), 128'(0));
      check("rst_out_data", C, out_data, 128'h0);
      check("rst_in_ready", C, 128'(in_ready), 128'(1));
      check("rst_busy", C, 128'(busy), 128'(0));
      tick();
      run_one(FIPS_IN, 1'b0, FIPS_OUT, "post_reset");

`ifdef MIXCOL_INV_EN
      run_one(FIPS_OUT, 1'b1, FIPS_IN, "inverse");
`endif

      // Random traffic: inputs toggle every cycle, occasional reset.
      for (int i = 0; i < 400; i++) begin
        rst_n     = ($urandom_range(0, 99) != 0);
        in_valid  = $urandom_range(0, 1) != 0;
        in_data   = {$urandom, $urandom, $urandom, $urandom};
        out_ready = ($urandom_range(0, 3) != 0);
        inv       = $urandom_range(0, 1) != 0;
        tick();
      end
      rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      repeat (8) tick();
      done_cnt++;
    end
  end

  initial begin
    int cyc;
    check("model_fips", 0, ref_mix(FIPS_IN, 1'b0), FIPS_OUT);
    check("model_c6", 0, ref_mix(C6_IN, 1'b0), C6_OUT);
    check("model_inv", 0, ref_mix(FIPS_OUT, 1'b1), FIPS_IN);
    cyc = 0;
    while (done_cnt < 3 && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    checks++;
    if (done_cnt < 3) begin
      errors++;
      $display("FAIL timeout: finished instances %0d want 3", done_cnt);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
